// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM state type and
// small op-class helpers used by both the top and the bench-visible ports.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'h0;
    localparam logic [3:0] OP_OR    = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_NOR   = 4'h4;
    localparam logic [3:0] OP_SLL   = 4'h5;
    localparam logic [3:0] OP_SRL   = 4'h6;
    localparam logic [3:0] OP_SRA   = 4'h7;
    localparam logic [3:0] OP_SLT   = 4'h8;
    localparam logic [3:0] OP_SLTU  = 4'h9;
    localparam logic [3:0] OP_LUI   = 4'hA;
    localparam logic [3:0] OP_XOR   = 4'hB;
    localparam logic [3:0] OP_MULT  = 4'hC;
    localparam logic [3:0] OP_MULTU = 4'hD;
    localparam logic [3:0] OP_DIV   = 4'hE;
    localparam logic [3:0] OP_DIVU  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

    // Ops C..F go through the iterative multiply/divide engine.
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3] & op[2];
    endfunction

    // Signed multiply/divide need magnitude conversion and sign fix-up.
    function automatic logic is_signed_md(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative engine on unsigned magnitudes: shift-add multiply or
// restoring divide, one bit per cycle for exactly WIDTH cycles after start.
// Result layout in acc: multiply {hi,lo} = product, divide {rem,quot}.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CW = $clog2(WIDTH);

    logic               busy_q, busy_d;
    logic               div_q, div_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;

    // done marks the cycle of the final iteration step
    assign done   = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign res_hi = acc_q[2*WIDTH-1:WIDTH];
    assign res_lo = acc_q[WIDTH-1:0];

    // One iteration step of multiply or divide, or a fresh load on start
    always_comb begin
        busy_d  = busy_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mb_d    = mb_q;
        add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : '0);
        trial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mb_q};
        if (start) begin
            busy_d = 1'b1;
            div_d  = is_div;
            cnt_d  = '0;
            mb_d   = opb;
            acc_d  = {{WIDTH{1'b0}}, opa};
        end else if (busy_q) begin
            cnt_d = cnt_q + CW'(1);
            if (done) busy_d = 1'b0;
            if (!div_q) begin
                // add multiplicand into the high half when the LSB is set, then shift right
                acc_d = {add_sum, acc_q[WIDTH-1:1]};
            end else if (!trial[WIDTH]) begin
                // subtraction fits: keep the difference, quotient bit 1
                acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                // restore: plain shift, quotient bit 0
                acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end
        end
    end

    // Engine state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            mb_q   <= '0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            mb_q   <= mb_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes. Logic ops finish in one cycle;
// multiply/divide run WIDTH cycles in the iterative engine plus one sign-fix
// cycle. Results are held in DONE until the consumer takes them.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic             out_zero,
    output logic             out_ovf
);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    alu_state_e       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic             ovf_q, ovf_d;

    logic             accept, md_start, it_done;
    logic [WIDTH-1:0] a_mag, b_mag, it_hi, it_lo;
    logic [WIDTH-1:0] alu_lo, sum, diff;
    logic             alu_ovf;
    logic [SHW-1:0]   shamt;
    logic             neg_a, neg_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    assign accept   = in_valid && in_ready;
    assign md_start = accept && is_muldiv(op);
    assign shamt    = b[SHW-1:0];
    assign a_mag    = (is_signed_md(op) && a[WIDTH-1]) ? -a : a;
    assign b_mag    = (is_signed_md(op) && b[WIDTH-1]) ? -b : b;

    assign out_lo   = lo_q;
    assign out_hi   = hi_q;
    assign out_ovf  = ovf_q;
    assign out_zero = (lo_q == '0);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (op[1]),
        .opa    (a_mag),
        .opb    (b_mag),
        .done   (it_done),
        .res_hi (it_hi),
        .res_lo (it_lo)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_muldiv(op) ? ST_ITER : ST_DONE;
            ST_ITER: if (it_done) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; in_ready stays low while reset is held
    always_comb begin
        in_ready  = rst_n && (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Single-cycle ALU result for ops 0..B
    always_comb begin
        alu_lo  = '0;
        alu_ovf = 1'b0;
        sum     = a + b;
        diff    = a - b;
        case (op)
            OP_AND:  alu_lo = a & b;
            OP_OR:   alu_lo = a | b;
            OP_ADD: begin
                alu_lo  = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_lo  = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOR:  alu_lo = ~(a | b);
            OP_SLL:  alu_lo = a << shamt;
            OP_SRL:  alu_lo = a >> shamt;
            OP_SRA:  alu_lo = $signed(a) >>> shamt;
            OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_lo = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_LUI:  alu_lo = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_XOR:  alu_lo = a ^ b;
            default: alu_lo = '0;
        endcase
    end

    // Result capture: on a single-cycle accept, or from the engine in FIX
    always_comb begin
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        lo_d  = lo_q;
        hi_d  = hi_q;
        ovf_d = ovf_q;
        neg_a = is_signed_md(op_q) && a_q[WIDTH-1];
        neg_b = is_signed_md(op_q) && b_q[WIDTH-1];
        prod  = {it_hi, it_lo};
        quo   = it_lo;
        rem   = it_hi;
        if (neg_a ^ neg_b) begin
            prod = -prod;
            quo  = -quo;
        end
        if (neg_a) rem = -rem;
        if (accept) begin
            op_d = op;
            a_d  = a;
            b_d  = b;
            if (!is_muldiv(op)) begin
                lo_d  = alu_lo;
                hi_d  = '0;
                ovf_d = alu_ovf;
            end
        end else if (state_q == ST_FIX) begin
            if (!op_q[1]) begin
                lo_d  = prod[WIDTH-1:0];
                hi_d  = prod[2*WIDTH-1:WIDTH];
                ovf_d = 1'b0;
            end else if (b_q == '0) begin
                lo_d  = '1;
                hi_d  = a_q;
                ovf_d = 1'b1;
            end else begin
                // MIN / -1 wraps back to MIN through the magnitude path; just flag it
                lo_d  = quo;
                hi_d  = rem;
                ovf_d = (op_q == OP_DIV) && (a_q == MIN_VAL) && (b_q == '1);
            end
        end
    end

    // Operand and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            lo_q  <= '0;
            hi_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            lo_q  <= lo_d;
            hi_q  <= hi_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: 32-bit and 16-bit instances, table of vectors
// with hand-computed results plus handshake-stall and mid-op reset sequences.
module tb_alu_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        v32, r32, ov32, ordy32, z32, f32;
    logic [3:0]  op32;
    logic [31:0] a32, b32, lo32, hi32;

    logic        v16, r16, ov16, ordy16, z16, f16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, lo16, hi16;

    alu_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .op(op32),
        .a(a32), .b(b32), .out_valid(ov32), .out_ready(ordy32),
        .out_lo(lo32), .out_hi(hi32), .out_zero(z32), .out_ovf(f32)
    );

    alu_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .op(op16),
        .a(a16), .b(b16), .out_valid(ov16), .out_ready(ordy16),
        .out_lo(lo16), .out_hi(hi16), .out_zero(z16), .out_ovf(f16)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t tbl32[25];
    vec_t tbl16[6];

    // Issue one request on the 32-bit DUT, measure latency, then drain it
    task automatic run32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi,
                         output logic ovf, output logic z, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!r32 && w < 100) begin @(negedge clk); w++; end
        check("in_ready32 before accept", r32, 1);
        v32 = 1'b1; op32 = o; a32 = a; b32 = b;
        @(posedge clk); #1;
        v32 = 1'b0;
        lat = 1;
        while (!ov32 && lat < 100) begin @(posedge clk); #1; lat++; end
        lo = lo32; hi = hi32; ovf = f32; z = z32;
        ordy32 = 1'b1;
        @(posedge clk); #1;
        ordy32 = 1'b0;
    endtask

    task automatic run16(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] lo, output logic [15:0] hi,
                         output logic ovf, output logic z, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!r16 && w < 100) begin @(negedge clk); w++; end
        check("in_ready16 before accept", r16, 1);
        v16 = 1'b1; op16 = o; a16 = a; b16 = b;
        @(posedge clk); #1;
        v16 = 1'b0;
        lat = 1;
        while (!ov16 && lat < 100) begin @(posedge clk); #1; lat++; end
        lo = lo16; hi = hi16; ovf = f16; z = z16;
        ordy16 = 1'b1;
        @(posedge clk); #1;
        ordy16 = 1'b0;
    endtask

    initial begin
        logic [31:0] lo, hi;
        logic [15:0] l16, h16;
        logic        ovf, z;
        int          lat, seen;

        tbl32[0]  = '{"add ovf",      4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b1, 1};
        tbl32[1]  = '{"add",          4'h2, 32'h00000005, 32'h00000003, 32'h00000008, 32'h0, 1'b0, 1};
        tbl32[2]  = '{"sub ovf",      4'h3, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b1, 1};
        tbl32[3]  = '{"sub neg",      4'h3, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h0, 1'b0, 1};
        tbl32[4]  = '{"sub zero",     4'h3, 32'h12345678, 32'h12345678, 32'h00000000, 32'h0, 1'b0, 1};
        tbl32[5]  = '{"and",          4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1};
        tbl32[6]  = '{"or",           4'h1, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 32'h0, 1'b0, 1};
        tbl32[7]  = '{"nor",          4'h4, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1};
        tbl32[8]  = '{"xor",          4'hB, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 32'h0, 1'b0, 1};
        tbl32[9]  = '{"sll 31",       4'h5, 32'h00000001, 32'h0000001F, 32'h80000000, 32'h0, 1'b0, 1};
        tbl32[10] = '{"sll mask",     4'h5, 32'h00000001, 32'h00000021, 32'h00000002, 32'h0, 1'b0, 1};
        tbl32[11] = '{"srl",          4'h6, 32'h80000000, 32'h00000004, 32'h08000000, 32'h0, 1'b0, 1};
        tbl32[12] = '{"sra",          4'h7, 32'h80000000, 32'h00000004, 32'hF8000000, 32'h0, 1'b0, 1};
        tbl32[13] = '{"slt min<max",  4'h8, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 32'h0, 1'b0, 1};
        tbl32[14] = '{"slt max<min",  4'h8, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h0, 1'b0, 1};
        tbl32[15] = '{"sltu",         4'h9, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h0, 1'b0, 1};
        tbl32[16] = '{"lui",          4'hA, 32'h00000000, 32'h1234ABCD, 32'hABCD0000, 32'h0, 1'b0, 1};
        tbl32[17] = '{"mult -1*2",    4'hC, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 34};
        tbl32[18] = '{"multu",        4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 34};
        tbl32[19] = '{"mult min*min", 4'hC, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 34};
        tbl32[20] = '{"div -7/2",     4'hE, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34};
        tbl32[21] = '{"div 7/-2",     4'hE, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 34};
        tbl32[22] = '{"divu 7/0",     4'hF, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h00000007, 1'b1, 34};
        tbl32[23] = '{"div min/-1",   4'hE, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 34};
        tbl32[24] = '{"div -5/0",     4'hE, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 34};

        tbl16[0]  = '{"w16 slt",      4'h8, 32'h8000, 32'h7FFF, 32'h0001, 32'h0, 1'b0, 1};
        tbl16[1]  = '{"w16 sra 15",   4'h7, 32'h8000, 32'h000F, 32'hFFFF, 32'h0, 1'b0, 1};
        tbl16[2]  = '{"w16 lui",      4'hA, 32'h0000, 32'h00AB, 32'hAB00, 32'h0, 1'b0, 1};
        tbl16[3]  = '{"w16 add ovf",  4'h2, 32'h7FFF, 32'h0001, 32'h8000, 32'h0, 1'b1, 1};
        tbl16[4]  = '{"w16 mult",     4'hC, 32'hFFFF, 32'h0002, 32'hFFFE, 32'hFFFF, 1'b0, 18};
        tbl16[5]  = '{"w16 divu",     4'hF, 32'h0064, 32'h0007, 32'h000E, 32'h0002, 1'b0, 18};

        rst_n = 1'b0;
        v32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; ordy32 = 1'b0;
        v16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; ordy16 = 1'b0;

        // reset state
        #13;
        check("rst out_valid", ov32, 0);
        check("rst in_ready",  r32,  0);
        check("rst out_lo",    lo32, 0);
        check("rst out_hi",    hi32, 0);
        check("rst out_ovf",   f32,  0);
        check("rst out_zero",  z32,  1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            run32(tbl32[i].op, tbl32[i].a, tbl32[i].b, lo, hi, ovf, z, lat);
            check({tbl32[i].name, " lo"},   lo,  tbl32[i].lo);
            check({tbl32[i].name, " hi"},   hi,  tbl32[i].hi);
            check({tbl32[i].name, " ovf"},  ovf, tbl32[i].ovf);
            check({tbl32[i].name, " zero"}, z,   tbl32[i].lo == 32'h0);
            check({tbl32[i].name, " lat"},  lat, tbl32[i].lat);
        end

        for (int i = 0; i < 6; i++) begin
            run16(tbl16[i].op, tbl16[i].a[15:0], tbl16[i].b[15:0], l16, h16, ovf, z, lat);
            check({tbl16[i].name, " lo"},  l16, tbl16[i].lo[15:0]);
            check({tbl16[i].name, " hi"},  h16, tbl16[i].hi[15:0]);
            check({tbl16[i].name, " ovf"}, ovf, tbl16[i].ovf);
            check({tbl16[i].name, " lat"}, lat, tbl16[i].lat);
        end

        // stall in DONE for 5 cycles with a competing request that must be dropped
        @(negedge clk);
        v32 = 1'b1; op32 = 4'h2; a32 = 32'd5; b32 = 32'd3;
        @(posedge clk); #1;
        op32 = 4'h2; a32 = 32'd1; b32 = 32'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall out_valid", ov32, 1);
            check("stall in_ready",  r32,  0);
            check("stall out_lo",    lo32, 32'd8);
            check("stall out_ovf",   f32,  0);
            @(posedge clk); #1;
        end
        v32 = 1'b0;
        ordy32 = 1'b1;
        @(posedge clk); #1;
        ordy32 = 1'b0;
        @(negedge clk);
        check("post-stall out_valid", ov32, 0);
        check("post-stall in_ready",  r32,  1);
        check("post-stall out_lo",    lo32, 32'd8);

        // reset pulse in the middle of a divu
        @(negedge clk);
        v32 = 1'b1; op32 = 4'hF; a32 = 32'd100; b32 = 32'd7;
        @(posedge clk); #1;
        v32 = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("iter out_valid", ov32, 0);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", ov32, 0);
        check("abort in_ready",  r32,  0);
        check("abort out_lo",    lo32, 0);
        check("abort out_hi",    hi32, 0);
        check("abort out_zero",  z32,  1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("release in_ready", r32, 1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ov32) seen++;
        end
        check("no stale out_valid", seen, 0);

        // engine recovers cleanly after the abort
        run32(4'hF, 32'd100, 32'd7, lo, hi, ovf, z, lat);
        check("recover divu lo",  lo,  32'd14);
        check("recover divu hi",  hi,  32'd2);
        check("recover divu lat", lat, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
